sig_sweep: RTL and testbench

Parametrised operand-sweep generator and signed/unsigned arithmetic checker. Each run steps a 2W-bit counter through every operand pair, computes signed and unsigned results for the selected operation in parallel through a PIPE-stage pipeline, and accumulates modular checksums of both result streams. It sits at the top of the FPGA signedness test design and drives board outputs or a logic analyser. A start/busy/done handshake controls each run, and a hold input pauses it.

---
 rtl/sig_sweep.sv | 187 ++++++++++++++++++
 tb/tb_sig_sweep.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_sweep.sv
// sig_sweep: operand-sweep generator with a signed/unsigned arithmetic checker.
//
// A 2W-bit counter walks every (x1, x2) operand pair, x1 = x[W-1:0] and
// x2 = x[2W-1:W]. Each pair feeds a signed and an unsigned multiply or add,
// selected by the operation latched at start. The result goes through a
// PIPE-stage pipeline. Both result streams are accumulated into modular
// checksums.
//
// Ports
//   iCLK, iRST_N      clock, asynchronous active-low reset
//   iSTART            start request, sampled only while idle
//   iOP               0 = multiply, 1 = add (latched at start)
//   iHOLD             freezes counter, pipeline and drain countdown
//   oX1, oX2          operands aligned with the results
//   oSY, oUY          signed / unsigned result, 2W bits
//   oVALID            outputs carry a fresh result this cycle
//   oBUSY             run or drain in progress
//   oDONE             one-cycle end-of-run pulse
//   oSUM_S, oSUM_U    modular sums of sign-/zero-extended results
module sig_sweep #(
    parameter int W    = 4,
    parameter int PIPE = 2,
    parameter int SUMW = 16
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iSTART,
    input  logic            iOP,
    input  logic            iHOLD,
    output logic [W-1:0]    oX1,
    output logic [W-1:0]    oX2,
    output logic [2*W-1:0]  oSY,
    output logic [2*W-1:0]  oUY,
    output logic            oVALID,
    output logic            oBUSY,
    output logic            oDONE,
    output logic [SUMW-1:0] oSUM_S,
    output logic [SUMW-1:0] oSUM_U
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2*W-1:0] X_ONE      = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [2:0]     DRAIN_LAST = 3'(PIPE - 1);

    logic [1:0]     state;
    logic [2*W-1:0] x;
    logic           op;
    logic [2:0]     drain_cnt;

    logic [PIPE:1]             vld_pipe;
    logic [PIPE:1][W-1:0]      p_x1;
    logic [PIPE:1][W-1:0]      p_x2;
    logic [PIPE:1][2*W-1:0]    p_sy;
    logic [PIPE:1][2*W-1:0]    p_uy;

    logic           start_acc;
    logic           adv;
    logic           issue;
    logic [W-1:0]   x1;
    logic [W-1:0]   x2;
    logic [2*W-1:0] sx1, sx2, zx1, zx2;
    logic [2*W-1:0] sy_new, uy_new;
    logic [SUMW-1:0] sy_ext, uy_ext;

    assign start_acc = (state == S_IDLE) && iSTART;
    // Everything that moves during a run advances only on unheld cycles.
    assign adv   = ((state == S_RUN) || (state == S_DRAIN)) && !iHOLD;
    assign issue = (state == S_RUN) && !iHOLD;

    assign x1  = x[W-1:0];
    assign x2  = x[2*W-1:W];
    assign sx1 = {{W{x1[W-1]}}, x1};
    assign sx2 = {{W{x2[W-1]}}, x2};
    assign zx1 = {{W{1'b0}}, x1};
    assign zx2 = {{W{1'b0}}, x2};

    // The 2W-bit product/sum of the extended operands is exact for both
    // interpretations, so no overflow handling is needed.
    always_comb begin
        sy_new = sx1 + sx2;
        uy_new = zx1 + zx2;
        if (!op) begin
            sy_new = sx1 * sx2;
            uy_new = zx1 * zx2;
        end
    end

    // Control FSM and operand counter.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= S_IDLE;
            x         <= '0;
            op        <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iSTART) begin
                        state <= S_RUN;
                        x     <= '0;
                        op    <= iOP;
                    end
                end
                S_RUN: begin
                    if (!iHOLD) begin
                        x <= x + X_ONE;
                        // Last pair issued: counter wraps, nothing reissued.
                        if (&x) begin
                            state     <= S_DRAIN;
                            drain_cnt <= DRAIN_LAST;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!iHOLD) begin
                        if (drain_cnt == 3'd0) state <= S_DONE;
                        else                   drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result pipeline. Valid bits always shift while advancing, but a stage's
    // data only loads when a valid result arrives, so the output stage keeps
    // the last real result after the run drains.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vld_pipe <= '0;
            p_x1     <= '0;
            p_x2     <= '0;
            p_sy     <= '0;
            p_uy     <= '0;
        end else if (start_acc) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= issue;
            if (issue) begin
                p_x1[1] <= x1;
                p_x2[1] <= x2;
                p_sy[1] <= sy_new;
                p_uy[1] <= uy_new;
            end
            for (int k = 2; k <= PIPE; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) begin
                    p_x1[k] <= p_x1[k-1];
                    p_x2[k] <= p_x2[k-1];
                    p_sy[k] <= p_sy[k-1];
                    p_uy[k] <= p_uy[k-1];
                end
            end
        end
    end

    assign oX1    = p_x1[PIPE];
    assign oX2    = p_x2[PIPE];
    assign oSY    = p_sy[PIPE];
    assign oUY    = p_uy[PIPE];
    // A held cycle presents nothing new; the frozen result is shown again
    // as valid once the hold lifts, so each result is counted exactly once.
    assign oVALID = vld_pipe[PIPE] && !iHOLD;
    assign oBUSY  = (state == S_RUN) || (state == S_DRAIN);
    assign oDONE  = (state == S_DONE);

    assign sy_ext = SUMW'($signed(oSY));
    assign uy_ext = SUMW'(oUY);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oSUM_S <= '0;
            oSUM_U <= '0;
        end else if (start_acc) begin
            oSUM_S <= '0;
            oSUM_U <= '0;
        end else if (oVALID) begin
            oSUM_S <= oSUM_S + sy_ext;
            oSUM_U <= oSUM_U + uy_ext;
        end
    end

endmodule

// File: tb/tb_sig_sweep.sv
// Testbench for sig_sweep. Four instances cover W=4/PIPE=2 (main), PIPE=1,
// PIPE=4 and W=3. On every accepted start the expected result stream is
// pushed into a per-instance queue; a negedge monitor pops and compares
// whenever oVALID is high and checks timing and checksums at oDONE.
module tb_sig_sweep;

    function automatic int w_of(input int g);
        return (g == 3) ? 3 : 4;
    endfunction
    function automatic int p_of(input int g);
        return (g == 1) ? 1 : ((g == 2) ? 4 : 2);
    endfunction

    // Hand-computed final checksums (sum over all pairs, mod 2^16).
    function automatic int exp_sum(input int w, input bit op, input bit sgn);
        if (w == 4) begin
            if (!op) return sgn ? 32'h0040 : 32'h3840;
            else     return sgn ? 32'hFF00 : 32'h0F00;
        end else begin
            if (!op) return sgn ? 32'h0010 : 32'h0310;
            else     return sgn ? 32'hFFC0 : 32'h01C0;
        end
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start;
    logic       op_in;
    logic       hold = 1'b0;
    bit         hold_en = 1'b0;

    int edges = 0;
    int start_edge[4] = '{0, 0, 0, 0};
    int arm_cnt[4]    = '{0, 0, 0, 0};
    int done_cnt[4]   = '{0, 0, 0, 0};
    bit exp_op = 1'b0;
    int n_pass = 0;
    int n_total = 0;

    int hold_cyc[10] = '{3, 4, 20, 57, 100, 101, 102, 180, 230, 249};

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit in_hold_set(input int c);
        for (int i = 0; i < 10; i++) if (hold_cyc[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Hold pattern for the main instance, indexed by cycle within its run.
    always @(posedge clk) begin
        #2;
        hold = hold_en && in_hold_set(edges - start_edge[0] + 1);
    end

    for (genvar g = 0; g < 4; g++) begin : gen
        localparam int GW = w_of(g);
        localparam int GP = p_of(g);
        localparam int M  = 1 << GW;
        localparam int N  = 1 << (2 * GW);

        logic [GW-1:0]   x1, x2;
        logic [2*GW-1:0] sy, uy;
        logic            vld, busy, done;
        logic [15:0]     ss, su;

        sig_sweep #(.W(GW), .PIPE(GP), .SUMW(16)) dut (
            .iCLK   (clk),
            .iRST_N (rst_n),
            .iSTART (start[g]),
            .iOP    (op_in),
            .iHOLD  (hold),
            .oX1    (x1),
            .oX2    (x2),
            .oSY    (sy),
            .oUY    (uy),
            .oVALID (vld),
            .oBUSY  (busy),
            .oDONE  (done),
            .oSUM_S (ss),
            .oSUM_U (su)
        );

        int q[$];
        int seen = 0;
        int vcnt = 0;
        int held = 0;
        bit active = 1'b0;
        bit op_r = 1'b0;

        always @(negedge clk) begin : mon
            int cyc;
            int e;
            cyc = edges - start_edge[g] + 1;
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                if (arm_cnt[g] != seen) begin
                    seen = arm_cnt[g];
                    op_r = exp_op;
                    q.delete();
                    for (int i = 0; i < N; i++) begin
                        int a1, a2, s1, s2, ey, eu;
                        a1 = i % M;
                        a2 = i / M;
                        s1 = (a1 >= M / 2) ? a1 - M : a1;
                        s2 = (a2 >= M / 2) ? a2 - M : a2;
                        ey = (op_r ? s1 + s2 : s1 * s2) & (N - 1);
                        eu = (op_r ? a1 + a2 : a1 * a2) & (N - 1);
                        q.push_back((a2 << (5 * GW)) | (a1 << (4 * GW)) | (ey << (2 * GW)) | eu);
                    end
                    vcnt = 0;
                    held = 0;
                    active = 1'b1;
                end
                if (active) begin
                    if (hold && cyc >= 1 && cyc <= N + GP + held) begin
                        held++;
                        chk($sformatf("i%0d valid on hold c%0d", g, cyc), int'(vld), 0);
                    end
                    chk($sformatf("i%0d busy c%0d", g, cyc), int'(busy),
                        int'(cyc >= 1 && cyc <= N + GP + held));
                    if (vld) begin
                        if (q.size() == 0) begin
                            chk($sformatf("i%0d extra valid", g), 1, 0);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("i%0d pair{x2,x1,sy,uy} c%0d", g, cyc),
                                int'({x2, x1, sy, uy}), e);
                            vcnt++;
                        end
                    end
                    if (done) begin
                        chk($sformatf("i%0d done cycle", g), cyc, N + GP + 1 + held);
                        chk($sformatf("i%0d valid count", g), vcnt, N);
                        chk($sformatf("i%0d sum_s", g), int'(ss), exp_sum(GW, op_r, 1'b1));
                        chk($sformatf("i%0d sum_u", g), int'(su), exp_sum(GW, op_r, 1'b0));
                        active = 1'b0;
                        done_cnt[g]++;
                    end
                end else if (vld || done) begin
                    chk($sformatf("i%0d unexpected valid/done", g), int'({vld, done}), 0);
                end
            end
        end
    end

    // Hand-computed spot values on the main instance.
    always @(negedge clk) begin
        if (rst_n && gen[0].active && gen[0].vld) begin
            if (!gen[0].op_r && gen[0].x1 == 4'h8 && gen[0].x2 == 4'hF) begin
                chk("mul 8*F sy", int'(gen[0].sy), 32'h08);
                chk("mul 8*F uy", int'(gen[0].uy), 32'h78);
            end
            if (!gen[0].op_r && gen[0].x1 == 4'hF && gen[0].x2 == 4'hF) begin
                chk("mul F*F sy", int'(gen[0].sy), 32'h01);
                chk("mul F*F uy", int'(gen[0].uy), 32'hE1);
            end
            if (gen[0].op_r && gen[0].x1 == 4'h8 && gen[0].x2 == 4'h8) begin
                chk("add 8+8 sy", int'(gen[0].sy), 32'hF0);
                chk("add 8+8 uy", int'(gen[0].uy), 32'h10);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, " x1"},    int'(gen[0].x1), 0);
        chk({tag, " x2"},    int'(gen[0].x2), 0);
        chk({tag, " sy"},    int'(gen[0].sy), 0);
        chk({tag, " uy"},    int'(gen[0].uy), 0);
        chk({tag, " valid"}, int'(gen[0].vld), 0);
        chk({tag, " busy"},  int'(gen[0].busy), 0);
        chk({tag, " done"},  int'(gen[0].done), 0);
        chk({tag, " sum_s"}, int'(gen[0].ss), 0);
        chk({tag, " sum_u"}, int'(gen[0].su), 0);
    endtask

    task automatic wait_done(input int g, input int prev);
        int k = 0;
        while (done_cnt[g] == prev && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("i%0d done seen within bound", g), int'(done_cnt[g] != prev), 1);
    endtask

    task automatic begin_run(input int g, input bit op);
        @(negedge clk);
        op_in    = op;
        exp_op   = op;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start_edge[g] = edges;
        arm_cnt[g]++;
    endtask

    task automatic run_pulse(input int g, input bit op);
        int prev;
        prev = done_cnt[g];
        begin_run(g, op);
        start[g] = 1'b0;
        wait_done(g, prev);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // iSTART held high: each new run begins two cycles after oDONE's cycle.
    task automatic run_b2b(input int g, input bit op, input int runs);
        int prev;
        prev = done_cnt[g];
        begin_run(g, op);
        for (int r = 0; r < runs; r++) begin
            wait_done(g, prev);
            prev = done_cnt[g];
            if (r < runs - 1) begin
                start_edge[g] = start_edge[g] + (1 << (2 * w_of(g))) + p_of(g) + 2;
                arm_cnt[g]++;
            end else begin
                start[g] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : drive
        int prev;
        rst_n = 1'b0;
        start = '0;
        op_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_pulse(0, 1'b0);
        run_pulse(0, 1'b1);

        hold_en = 1'b1;
        run_pulse(0, 1'b0);
        hold_en = 1'b0;

        // Reset in the middle of a run.
        prev = done_cnt[0];
        begin_run(0, 1'b0);
        start[0] = 1'b0;
        while (edges - start_edge[0] + 1 < 100) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk_zero("mid-run reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset busy", int'(gen[0].busy), 0);
        chk("post-reset done", int'(gen[0].done), 0);
        repeat (300) @(posedge clk);
        #1;
        chk("no done after abort", done_cnt[0], prev);
        run_pulse(0, 1'b0);

        run_b2b(0, 1'b0, 2);
        run_b2b(1, 1'b0, 2);
        run_b2b(2, 1'b1, 2);
        run_b2b(3, 1'b0, 2);
        run_b2b(3, 1'b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
